pc_fetch_unit: RTL and testbench

- Parametrised successor to the combinational next-PC logic: owns the fetch-stage PC register and resolves D-stage branches and jumps.
- Adds a generalised branch-compare set, stall hold, exception and eret redirect, and an instruction-memory ready handshake.
- Latches a redirect that arrives while fetch is blocked, so a D-stage branch is never lost.
- Flags fetch address errors (AdEL). Sits between hazard control, the D-stage comparator operands and IM.

---
 rtl/pc_fetch_pkg.sv | 29 ++
 rtl/pc_fetch_unit_br_cond_eval.sv | 38 +++
 rtl/pc_fetch_unit.sv | 121 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_pkg
//  Purpose  : Shared encodings and default addresses for the fetch-stage PC.
//  Revision : 1.0 - initial release
// ============================================================================
package pc_fetch_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_GTZ  = 3'd3,
        BR_LEZ  = 3'd4,
        BR_LTZ  = 3'd5,
        BR_GEZ  = 3'd6
    } br_op_e;

    typedef enum logic [1:0] {
        JMP_NONE = 2'd0,
        JMP_J    = 2'd1,
        JMP_JR   = 2'd2
    } jmp_op_e;

    localparam logic [31:0] C_DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] C_DEFAULT_EXC_PC   = 32'h0000_4180;

endpackage : pc_fetch_pkg
`default_nettype wire

// File: rtl/pc_fetch_unit_br_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module   : br_cond_eval
//  Purpose  : Combinational branch-condition evaluator (shared with D-stage).
//  Revision : 1.0 - initial release
// ============================================================================
module br_cond_eval
    import pc_fetch_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [2:0]   br_op,
    input  logic [W-1:0] rs,
    input  logic [W-1:0] rt,
    output logic         taken
);

    logic w_rs_neg;
    logic w_rs_zero;

    assign w_rs_neg  = rs[W-1];
    assign w_rs_zero = (rs == '0);

    always_comb begin
        taken = 1'b0;
        case (br_op)
            BR_EQ:   taken = (rs == rt);
            BR_NE:   taken = (rs != rt);
            BR_GTZ:  taken = !w_rs_neg && !w_rs_zero;
            BR_LEZ:  taken = w_rs_neg || w_rs_zero;
            BR_LTZ:  taken = w_rs_neg;
            BR_GEZ:  taken = !w_rs_neg;
            default: taken = 1'b0;
        endcase
    end

endmodule : br_cond_eval
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_unit
//  Purpose  : Fetch PC register with branch/jump, exception/eret redirect and
//             a pending-redirect latch for cycles where IM is not ready.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(C_DEFAULT_RESET_PC),
    parameter logic [ADDR_W-1:0] EXC_PC     = ADDR_W'(C_DEFAULT_EXC_PC),
    parameter logic [ADDR_W-1:0] IMEM_BASE  = ADDR_W'(32'h0000_3000),
    parameter logic [ADDR_W-1:0] IMEM_BYTES = ADDR_W'(32'h0000_4000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              imem_ready,
    input  logic [2:0]        br_op,
    input  logic [1:0]        jmp_op,
    input  logic [ADDR_W-1:0] rs_val,
    input  logic [ADDR_W-1:0] rt_val,
    input  logic [25:0]       imm26,
    input  logic [ADDR_W-1:0] d_pc,
    input  logic              exc_req,
    input  logic              eret_req,
    input  logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] f_pc,
    output logic              fetch_req,
    output logic              adel,
    output logic              redir_pending
);

    // One extra bit so a window ending exactly at 2^ADDR_W does not wrap.
    localparam logic [ADDR_W:0] C_IMEM_END = {1'b0, IMEM_BASE} + {1'b0, IMEM_BYTES};

    logic [ADDR_W-1:0] r_f_pc;
    logic [ADDR_W-1:0] r_pend_pc;
    logic              r_pend_valid;

    logic              w_taken;
    logic              w_jump;
    logic              w_redirect;
    logic              w_adv;
    logic [ADDR_W-1:0] w_bt;
    logic [ADDR_W-1:0] w_jt;
    logic [ADDR_W-1:0] w_target;

    br_cond_eval #(
        .W     (ADDR_W)
    ) u_br_cond_eval (
        .br_op (br_op),
        .rs    (rs_val),
        .rt    (rt_val),
        .taken (w_taken)
    );

    assign w_bt = d_pc + ADDR_W'(4) + {{(ADDR_W-18){imm26[15]}}, imm26[15:0], 2'b00};

    generate
        if (ADDR_W > 28) begin : g_jt_region
            assign w_jt = {d_pc[ADDR_W-1:28], imm26, 2'b00};
        end else begin : g_jt_flat
            assign w_jt = {imm26, 2'b00};
        end
    endgenerate

    // The reserved jump encoding is treated as no jump, like reserved branches.
    assign w_jump     = (jmp_op == JMP_J) || (jmp_op == JMP_JR);
    assign w_redirect = w_taken || w_jump;
    assign w_adv      = !stall && imem_ready;

    always_comb begin
        w_target = w_bt;
        if (jmp_op == JMP_JR) begin
            w_target = rs_val;
        end else if (jmp_op == JMP_J) begin
            w_target = w_jt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_f_pc       <= RESET_PC;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= '0;
        end else if (exc_req) begin
            r_f_pc       <= EXC_PC;
            r_pend_valid <= 1'b0;
        end else if (eret_req) begin
            r_f_pc       <= epc;
            r_pend_valid <= 1'b0;
        end else if (stall) begin
            r_f_pc       <= r_f_pc;
        end else if (w_adv) begin
            r_pend_valid <= 1'b0;
            if (w_redirect) begin
                r_f_pc <= w_target;
            end else if (r_pend_valid) begin
                r_f_pc <= r_pend_pc;
            end else begin
                r_f_pc <= r_f_pc + ADDR_W'(4);
            end
        end else if (w_redirect) begin
            // IM blocked: keep the fetch address, remember where D wants to go.
            r_pend_pc    <= w_target;
            r_pend_valid <= 1'b1;
        end
    end

    assign f_pc          = r_f_pc;
    assign adel          = (r_f_pc[1:0] != 2'b00)
                         || (r_f_pc < IMEM_BASE)
                         || ({1'b0, r_f_pc} >= C_IMEM_END);
    assign fetch_req     = !adel;
    assign redir_pending = r_pend_valid;

endmodule : pc_fetch_unit
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_fetch_unit
//  Purpose  : Directed vector table plus randomized run against a reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;
    import pc_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, imem_ready, exc_req, eret_req;
    logic [2:0]  br_op;
    logic [1:0]  jmp_op;
    logic [31:0] rs_val, rt_val, d_pc, epc, f_pc;
    logic [25:0] imm26;
    logic        fetch_req, adel, redir_pending;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .imem_ready    (imem_ready),
        .br_op         (br_op),
        .jmp_op        (jmp_op),
        .rs_val        (rs_val),
        .rt_val        (rt_val),
        .imm26         (imm26),
        .d_pc          (d_pc),
        .exc_req       (exc_req),
        .eret_req      (eret_req),
        .epc           (epc),
        .f_pc          (f_pc),
        .fetch_req     (fetch_req),
        .adel          (adel),
        .redir_pending (redir_pending)
    );

    typedef struct {
        logic        rst, stall, rdy, exc, eret;
        logic [2:0]  br;
        logic [1:0]  jmp;
        logic [31:0] rs, rt, dpc, epc;
        logic [25:0] imm;
        logic [31:0] exp_pc;
        logic        exp_pend, exp_adel;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference state: architectural PC and the remembered redirect.
    logic [31:0] m_pc, m_pp;
    logic        m_pv;

    task automatic add(input int r, input int s, input int rd, input int br, input int jm,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                       input logic [31:0] dpc, input int ex, input int er, input logic [31:0] ep,
                       input logic [31:0] pc, input int pend, input int ad);
        vec_t v;
        v.rst = (r != 0);  v.stall = (s != 0);  v.rdy = (rd != 0);
        v.br  = 3'(br);    v.jmp   = 2'(jm);
        v.rs  = rs;        v.rt    = rt;        v.imm = imm[25:0];
        v.dpc = dpc;       v.exc   = (ex != 0); v.eret = (er != 0); v.epc = ep;
        v.exp_pc = pc;     v.exp_pend = (pend != 0); v.exp_adel = (ad != 0);
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        reset = v.rst;   stall = v.stall; imem_ready = v.rdy;
        br_op = v.br;    jmp_op = v.jmp;  rs_val = v.rs;  rt_val = v.rt;
        imm26 = v.imm;   d_pc = v.dpc;    exc_req = v.exc; eret_req = v.eret; epc = v.epc;
        @(posedge clk);
        #1;
        check({tag, " f_pc"}, f_pc, v.exp_pc);
        check({tag, " redir_pending"}, 32'(redir_pending), 32'(v.exp_pend));
        check({tag, " adel"}, 32'(adel), 32'(v.exp_adel));
        check({tag, " fetch_req"}, 32'(fetch_req), 32'(!v.exp_adel));
    endtask

    function automatic logic ref_taken(input logic [2:0] br, input logic [31:0] rs, input logic [31:0] rt);
        case (br)
            3'd1:    return rs == rt;
            3'd2:    return rs != rt;
            3'd3:    return $signed(rs) > 0;
            3'd4:    return $signed(rs) <= 0;
            3'd5:    return $signed(rs) < 0;
            3'd6:    return $signed(rs) >= 0;
            default: return 1'b0;
        endcase
    endfunction

    // Advances the reference one clock and fills in the expected outputs.
    task automatic model(input vec_t vi, output vec_t vo);
        logic        redir;
        logic [31:0] tgt;
        vo = vi;
        redir = ref_taken(vi.br, vi.rs, vi.rt) || vi.jmp == 2'd1 || vi.jmp == 2'd2;
        tgt = vi.dpc + 32'd4 + 32'(int'($signed(vi.imm[15:0])) * 4);
        if (vi.jmp == 2'd1) tgt = (vi.dpc & 32'hF000_0000) + {4'h0, vi.imm, 2'b00};
        if (vi.jmp == 2'd2) tgt = vi.rs;
        if (vi.rst) begin
            m_pc = 32'h3000; m_pv = 1'b0; m_pp = 32'h0;
        end else if (vi.exc) begin
            m_pc = 32'h4180; m_pv = 1'b0;
        end else if (vi.eret) begin
            m_pc = vi.epc;   m_pv = 1'b0;
        end else if (vi.stall) begin
            m_pc = m_pc;
        end else if (vi.rdy) begin
            m_pc = redir ? tgt : (m_pv ? m_pp : m_pc + 32'd4);
            m_pv = 1'b0;
        end else if (redir) begin
            m_pp = tgt; m_pv = 1'b1;
        end
        vo.exp_pc   = m_pc;
        vo.exp_pend = m_pv;
        vo.exp_adel = (m_pc % 4 != 0) || (m_pc < 32'h3000) || (m_pc >= 32'h7000);
    endtask

    initial begin
        //  rst stl rdy br      jmp     rs            rt      imm       dpc           ex er epc      exp_pc        pnd adel
        add(1, 0, 1, BR_NONE, JMP_NONE, 0,            0,      0,        0,            0, 0, 0,       'h3000,       0, 0);
        add(1, 0, 1, BR_NONE, JMP_NONE, 0,            0,      0,        0,            0, 0, 0,       'h3000,       0, 0);
        add(0, 0, 1, BR_NONE, JMP_NONE, 0,            0,      0,        0,            0, 0, 0,       'h3004,       0, 0);
        add(0, 0, 1, BR_NONE, JMP_NONE, 0,            0,      0,        0,            0, 0, 0,       'h3008,       0, 0);
        add(0, 0, 1, BR_EQ,   JMP_NONE, 5,            5,      'hFFFE,   'h3004,       0, 0, 0,       'h3000,       0, 0);
        add(0, 0, 1, BR_EQ,   JMP_NONE, 5,            6,      'hFFFE,   'h3004,       0, 0, 0,       'h3004,       0, 0);
        add(0, 0, 1, BR_GTZ,  JMP_NONE, 'h8000_0000,  0,      4,        'h3008,       0, 0, 0,       'h3008,       0, 0);
        add(0, 0, 1, BR_GTZ,  JMP_NONE, 1,            0,      4,        'h3008,       0, 0, 0,       'h301C,       0, 0);
        add(0, 0, 1, BR_GEZ,  JMP_NONE, 0,            0,      0,        'h301C,       0, 0, 0,       'h3020,       0, 0);
        add(0, 0, 0, BR_NONE, JMP_JR,   'h3010,       0,      0,        'h301C,       0, 0, 0,       'h3020,       1, 0);
        add(0, 0, 0, BR_NONE, JMP_NONE, 0,            0,      0,        0,            0, 0, 0,       'h3020,       1, 0);
        add(0, 0, 0, BR_NONE, JMP_NONE, 0,            0,      0,        0,            0, 0, 0,       'h3020,       1, 0);
        add(0, 0, 1, BR_NONE, JMP_NONE, 0,            0,      0,        0,            0, 0, 0,       'h3010,       0, 0);
        add(0, 0, 1, BR_NONE, JMP_NONE, 0,            0,      0,        0,            0, 0, 0,       'h3014,       0, 0);
        add(0, 0, 0, BR_NONE, JMP_JR,   'h3040,       0,      0,        'h3010,       0, 0, 0,       'h3014,       1, 0);
        add(0, 1, 0, BR_NONE, JMP_NONE, 0,            0,      0,        0,            1, 0, 0,       'h4180,       0, 0);
        add(0, 0, 1, BR_NONE, JMP_NONE, 0,            0,      0,        0,            0, 1, 'h3020,  'h3020,       0, 0);
        add(0, 0, 1, BR_NONE, JMP_JR,   'h3002,       0,      0,        'h3020,       0, 0, 0,       'h3002,       0, 1);
        add(0, 0, 1, BR_NONE, JMP_JR,   'h2FFC,       0,      0,        'h3020,       0, 0, 0,       'h2FFC,       0, 1);
        add(0, 0, 1, BR_NONE, JMP_NONE, 0,            0,      0,        0,            1, 1, 'h3020,  'h4180,       0, 0);
        add(0, 1, 1, BR_NONE, JMP_J,    0,            0,      'hC10,    'h4180,       0, 0, 0,       'h4180,       0, 0);
        add(0, 0, 1, BR_NONE, JMP_J,    0,            0,      'hC10,    'h4180,       0, 0, 0,       'h3040,       0, 0);
        add(0, 0, 1, BR_NONE, JMP_JR,   'h7000,       0,      0,        'h3040,       0, 0, 0,       'h7000,       0, 1);
        add(0, 0, 1, BR_NONE, JMP_JR,   'h6FFC,       0,      0,        'h3040,       0, 0, 0,       'h6FFC,       0, 0);
        add(0, 0, 0, BR_NONE, JMP_JR,   'h3100,       0,      0,        'h6FF8,       0, 0, 0,       'h6FFC,       1, 0);
        add(0, 0, 0, BR_NONE, JMP_JR,   'h3200,       0,      0,        'h6FF8,       0, 0, 0,       'h6FFC,       1, 0);
        add(0, 0, 1, BR_NONE, JMP_NONE, 0,            0,      0,        0,            0, 0, 0,       'h3200,       0, 0);
        add(0, 0, 1, BR_EQ,   JMP_JR,   'h3300,       'h3300, 'h10,     'h3200,       0, 0, 0,       'h3300,       0, 0);
        add(0, 0, 0, BR_NONE, JMP_JR,   'h3400,       0,      0,        'h3300,       0, 0, 0,       'h3300,       1, 0);
        add(0, 1, 1, BR_NONE, JMP_NONE, 0,            0,      0,        0,            0, 0, 0,       'h3300,       1, 0);
        add(0, 0, 1, BR_NONE, JMP_NONE, 0,            0,      0,        0,            0, 0, 0,       'h3400,       0, 0);
        add(0, 0, 1, BR_NONE, JMP_JR,   'hFFFF_FFFC,  0,      0,        'h3400,       0, 0, 0,       'hFFFF_FFFC,  0, 1);
        add(0, 0, 1, BR_NONE, JMP_NONE, 0,            0,      0,        0,            0, 0, 0,       'h0000_0000,  0, 1);
        add(0, 0, 1, BR_NONE, JMP_J,    0,            0,      'hC10,    'h5000_0000,  0, 0, 0,       'h5000_3040,  0, 1);

        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        for (int i = 0; i < 3000; i++) begin
            vec_t v;
            v.rst   = (i < 2) || ($urandom_range(0, 199) == 0);
            v.stall = ($urandom_range(0, 4) == 0);
            v.rdy   = ($urandom_range(0, 3) != 0);
            v.br    = 3'($urandom_range(0, 7));
            v.jmp   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
            v.rs    = ($urandom_range(0, 5) == 0) ? $urandom : 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
            v.rt    = $urandom_range(0, 1) ? v.rs : $urandom;
            v.imm   = 26'($urandom);
            v.dpc   = 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
            v.exc   = ($urandom_range(0, 49) == 0);
            v.eret  = ($urandom_range(0, 49) == 0);
            v.epc   = 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
            model(v, v);
            apply(v, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_pc_fetch_unit
`default_nettype wire
